// File: rtl/taiga_types.sv
// Shared AXI response codes, responder FSM states and the registered read-beat record.
package taiga_types;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_DATA} rd_state_e;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wr_state_e;

  typedef struct packed {
    logic [31:0] data;
    logic [5:0]  id;
    logic        last;
    logic [1:0]  resp;
  } rbeat_t;
endpackage

// File: rtl/ddr_sim_ram.sv
// Simple dual-port 32-bit backing store with byte-enable write and write-first read.
module ddr_sim_ram #(
  parameter int ADDR_W = 14
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [31:0]       wdata_i,
  input  logic [3:0]        wstrb_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [31:0]       rdata_o
);
  logic [31:0] mem_q [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we_i)
      for (int b = 0; b < 4; b++)
        if (wstrb_i[b]) mem_q[waddr_i][8*b +: 8] <= wdata_i[8*b +: 8];
  end

  // Bypass the same-edge write so a beat latched now already sees the new bytes.
  always_comb begin
    rdata_o = mem_q[raddr_i];
    if (we_i && (waddr_i == raddr_i))
      for (int b = 0; b < 4; b++)
        if (wstrb_i[b]) rdata_o[8*b +: 8] = wdata_i[8*b +: 8];
  end
endmodule

// File: rtl/ddr_axi_responder.sv
// AXI4 slave memory model: independent read/write FSMs over ddr_sim_ram.
// Define DDR_AXI_RESPONDER_RANGE_CHECK_EN to flag beats beyond the store with SLVERR.
module ddr_axi_responder
  import taiga_types::*;
#(
  parameter int MEM_ADDR_W   = 14,
  parameter int READ_LATENCY = 5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] ddr_axi_araddr,
  input  logic [7:0]  ddr_axi_arlen,
  input  logic [5:0]  ddr_axi_arid,
  input  logic        ddr_axi_arvalid,
  output logic        ddr_axi_arready,
  output logic [31:0] ddr_axi_rdata,
  output logic [5:0]  ddr_axi_rid,
  output logic        ddr_axi_rlast,
  output logic [1:0]  ddr_axi_rresp,
  output logic        ddr_axi_rvalid,
  input  logic        ddr_axi_rready,
  input  logic [31:0] ddr_axi_awaddr,
  input  logic [7:0]  ddr_axi_awlen,
  input  logic [5:0]  ddr_axi_awid,
  input  logic        ddr_axi_awvalid,
  output logic        ddr_axi_awready,
  input  logic [31:0] ddr_axi_wdata,
  input  logic [3:0]  ddr_axi_wstrb,
  input  logic        ddr_axi_wvalid,
  output logic        ddr_axi_wready,
  output logic [5:0]  ddr_axi_bid,
  output logic [1:0]  ddr_axi_bresp,
  output logic        ddr_axi_bvalid,
  input  logic        ddr_axi_bready
);
  localparam logic [3:0] LAT_LAST = 4'(READ_LATENCY - 1);

  rd_state_e   rstate_q, rstate_d;
  logic [29:0] raddr_q, raddr_d;
  logic [8:0]  rcnt_q, rcnt_d;
  logic [3:0]  lat_q, lat_d;
  rbeat_t      rbeat_q, rbeat_d;
  logic        rload;

  wr_state_e   wstate_q, wstate_d;
  logic [29:0] waddr_q, waddr_d;
  logic [8:0]  wcnt_q, wcnt_d;
  logic [5:0]  bid_q, bid_d;
  logic [1:0]  bresp_q, bresp_d;
  logic        ram_we;

  logic [31:0] ram_rdata;
  logic        r_oor, w_oor;
  logic        unused_bits;

  // Word addresses are tracked at full width so out-of-range beats stay visible.
`ifdef DDR_AXI_RESPONDER_RANGE_CHECK_EN
  assign r_oor = |raddr_q[29:MEM_ADDR_W];
  assign w_oor = |waddr_q[29:MEM_ADDR_W];
`else
  assign r_oor = 1'b0;
  assign w_oor = 1'b0;
`endif
  assign unused_bits = ^{ddr_axi_araddr[1:0], ddr_axi_awaddr[1:0],
                         raddr_q[29:MEM_ADDR_W], waddr_q[29:MEM_ADDR_W]};

  ddr_sim_ram #(.ADDR_W(MEM_ADDR_W)) u_ram (
    .clk     (clk),
    .we_i    (ram_we),
    .waddr_i (waddr_q[MEM_ADDR_W-1:0]),
    .wdata_i (ddr_axi_wdata),
    .wstrb_i (ddr_axi_wstrb),
    .raddr_i (raddr_q[MEM_ADDR_W-1:0]),
    .rdata_o (ram_rdata)
  );

  // raddr_q always points at the next word to fetch; rcnt_q counts beats not yet presented.
  always_comb begin
    rstate_d = rstate_q;
    raddr_d  = raddr_q;
    rcnt_d   = rcnt_q;
    lat_d    = lat_q;
    rbeat_d  = rbeat_q;
    rload    = 1'b0;
    case (rstate_q)
      R_IDLE: if (ddr_axi_arvalid) begin
        rstate_d   = R_WAIT;
        raddr_d    = ddr_axi_araddr[31:2];
        rcnt_d     = {1'b0, ddr_axi_arlen} + 9'd1;
        lat_d      = '0;
        rbeat_d.id = ddr_axi_arid;
      end
      R_WAIT: begin
        if (lat_q == LAT_LAST) begin
          rstate_d = R_DATA;
          rload    = 1'b1;
        end else begin
          lat_d = lat_q + 4'd1;
        end
      end
      R_DATA: if (ddr_axi_rready) begin
        if (rbeat_q.last) begin
          rstate_d     = R_IDLE;
          rbeat_d.last = 1'b0;
        end else begin
          rload = 1'b1;
        end
      end
      default: rstate_d = R_IDLE;
    endcase
    if (rload) begin
      rbeat_d.data = r_oor ? 32'd0 : ram_rdata;
      rbeat_d.resp = r_oor ? RESP_SLVERR : RESP_OKAY;
      rbeat_d.last = (rcnt_q == 9'd1);
      rcnt_d       = rcnt_q - 9'd1;
      raddr_d      = raddr_q + 30'd1;
    end
  end

  always_comb begin
    wstate_d = wstate_q;
    waddr_d  = waddr_q;
    wcnt_d   = wcnt_q;
    bid_d    = bid_q;
    bresp_d  = bresp_q;
    ram_we   = 1'b0;
    case (wstate_q)
      W_IDLE: if (ddr_axi_awvalid) begin
        wstate_d = W_DATA;
        waddr_d  = ddr_axi_awaddr[31:2];
        wcnt_d   = {1'b0, ddr_axi_awlen} + 9'd1;
        bid_d    = ddr_axi_awid;
        bresp_d  = RESP_OKAY;
      end
      W_DATA: if (ddr_axi_wvalid) begin
        ram_we  = !w_oor;
        if (w_oor) bresp_d = RESP_SLVERR;
        waddr_d = waddr_q + 30'd1;
        wcnt_d  = wcnt_q - 9'd1;
        if (wcnt_q == 9'd1) wstate_d = W_RESP;
      end
      W_RESP: if (ddr_axi_bready) wstate_d = W_IDLE;
      default: wstate_d = W_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rstate_q <= R_IDLE;
      raddr_q  <= '0;
      rcnt_q   <= '0;
      lat_q    <= '0;
      rbeat_q  <= '0;
      wstate_q <= W_IDLE;
      waddr_q  <= '0;
      wcnt_q   <= '0;
      bid_q    <= '0;
      bresp_q  <= RESP_OKAY;
    end else begin
      rstate_q <= rstate_d;
      raddr_q  <= raddr_d;
      rcnt_q   <= rcnt_d;
      lat_q    <= lat_d;
      rbeat_q  <= rbeat_d;
      wstate_q <= wstate_d;
      waddr_q  <= waddr_d;
      wcnt_q   <= wcnt_d;
      bid_q    <= bid_d;
      bresp_q  <= bresp_d;
    end
  end

  assign ddr_axi_arready = (rstate_q == R_IDLE);
  assign ddr_axi_rvalid  = (rstate_q == R_DATA);
  assign ddr_axi_rdata   = rbeat_q.data;
  assign ddr_axi_rid     = rbeat_q.id;
  assign ddr_axi_rlast   = rbeat_q.last;
  assign ddr_axi_rresp   = rbeat_q.resp;
  assign ddr_axi_awready = (wstate_q == W_IDLE);
  assign ddr_axi_wready  = (wstate_q == W_DATA);
  assign ddr_axi_bvalid  = (wstate_q == W_RESP);
  assign ddr_axi_bid     = bid_q;
  assign ddr_axi_bresp   = bresp_q;
endmodule

// File: tb/tb_ddr_axi_responder.sv
// Bench for ddr_axi_responder: directed table, corner sequences, random traffic vs a word-array model.
module tb_ddr_axi_responder;
  localparam int AW  = 14;
  localparam int LAT = 5;
`ifdef DDR_AXI_RESPONDER_RANGE_CHECK_EN
  localparam bit RC = 1'b1;
`else
  localparam bit RC = 1'b0;
`endif

  logic        clk = 1'b0, rst_n = 1'b0;
  logic [31:0] araddr = '0, awaddr = '0, wdata = '0;
  logic [7:0]  arlen = '0, awlen = '0;
  logic [5:0]  arid = '0, awid = '0;
  logic        arvalid = 1'b0, rready = 1'b0, awvalid = 1'b0, wvalid = 1'b0, bready = 1'b0;
  logic [3:0]  wstrb = '0;
  logic        arready, rlast, rvalid, awready, wready, bvalid;
  logic [31:0] rdata;
  logic [5:0]  rid, bid;
  logic [1:0]  rresp, bresp;

  always #5 clk = ~clk;

  ddr_axi_responder #(.MEM_ADDR_W(AW), .READ_LATENCY(LAT)) dut (
    .clk(clk), .rst_n(rst_n),
    .ddr_axi_araddr(araddr), .ddr_axi_arlen(arlen), .ddr_axi_arid(arid),
    .ddr_axi_arvalid(arvalid), .ddr_axi_arready(arready),
    .ddr_axi_rdata(rdata), .ddr_axi_rid(rid), .ddr_axi_rlast(rlast),
    .ddr_axi_rresp(rresp), .ddr_axi_rvalid(rvalid), .ddr_axi_rready(rready),
    .ddr_axi_awaddr(awaddr), .ddr_axi_awlen(awlen), .ddr_axi_awid(awid),
    .ddr_axi_awvalid(awvalid), .ddr_axi_awready(awready),
    .ddr_axi_wdata(wdata), .ddr_axi_wstrb(wstrb), .ddr_axi_wvalid(wvalid),
    .ddr_axi_wready(wready), .ddr_axi_bid(bid), .ddr_axi_bresp(bresp),
    .ddr_axi_bvalid(bvalid), .ddr_axi_bready(bready)
  );

  int n_vec = 0, n_err = 0;
  logic [31:0] mem_m [int];
  logic [31:0] wbuf [16];
  logic [3:0]  sbuf [16];

  function automatic bit oor(input logic [31:0] a);
    return RC && (a >= 32'(4 << AW));
  endfunction
  function automatic int widx(input logic [31:0] a);
    return int'((a >> 2) % (1 << AW));
  endfunction
  function automatic logic [31:0] model_rd(input logic [31:0] a);
    if (oor(a)) return 32'd0;
    if (!mem_m.exists(widx(a))) return 'x;
    return mem_m[widx(a)];
  endfunction
  function automatic void model_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] w;
    if (oor(a)) return;
    w = mem_m.exists(widx(a)) ? mem_m[widx(a)] : 'x;
    for (int b = 0; b < 4; b++) if (s[b]) w[8*b +: 8] = d[8*b +: 8];
    mem_m[widx(a)] = w;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual %h required %h", nm, act, exp);
    end
  endtask
  task automatic tmo(input string nm);
    n_vec++;
    n_err++;
    $display("FAIL %s: timed out waiting for DUT", nm);
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [31:0] addr, input int len, input logic [5:0] id, input bit rnd);
    int to;
    bit err;
    err = 1'b0;
    awaddr = addr; awlen = 8'(len); awid = id; awvalid = 1'b1;
    to = 0;
    while (!awready && to < 200) begin step(); to++; end
    if (to >= 200) tmo("awready");
    step();
    awvalid = 1'b0;
    for (int i = 0; i <= len; i++) begin
      if (rnd && $urandom_range(0, 2) == 0) begin
        wvalid = 1'b0;
        repeat ($urandom_range(1, 3)) step();
      end
      wvalid = 1'b1; wdata = wbuf[i]; wstrb = sbuf[i];
      to = 0;
      while (!wready && to < 200) begin step(); to++; end
      if (to >= 200) tmo("wready");
      step();
      model_wr(addr + 32'(4 * i), wbuf[i], sbuf[i]);
      err |= oor(addr + 32'(4 * i));
    end
    wvalid = 1'b0;
    if (rnd) repeat ($urandom_range(0, 3)) step();
    to = 0;
    while (!bvalid && to < 200) begin step(); to++; end
    if (to >= 200) tmo("bvalid");
    chk("bid", 32'(bid), 32'(id));
    chk("bresp", 32'(bresp), err ? 32'd2 : 32'd0);
    bready = 1'b1;
    step();
    bready = 1'b0;
    chk("bvalid_once", 32'(bvalid), 32'd0);
  endtask

  // mode 0: rready held high, 1: toggled 1/0, 2: random
  task automatic do_read(input logic [31:0] addr, input int len, input logic [5:0] id,
                         input int mode, output logic [31:0] first);
    int to, got;
    bit hold, tog;
    logic [31:0] pd, a;
    first = '0; pd = '0;
    araddr = addr; arlen = 8'(len); arid = id; arvalid = 1'b1;
    to = 0;
    while (!arready && to < 200) begin step(); to++; end
    if (to >= 200) tmo("arready");
    step();
    arvalid = 1'b0;
    to = 0;
    while (!rvalid && to < 200) begin step(); to++; end
    chk("rd_latency", 32'(to), 32'(LAT));
    got = 0; hold = 1'b0; tog = 1'b1; to = 0;
    while (got <= len && to < 2000) begin
      chk("rvalid_held", 32'(rvalid), 32'd1);
      if (hold) chk("rdata_stable", rdata, pd);
      case (mode)
        0: rready = 1'b1;
        1: begin rready = tog; tog = ~tog; end
        default: rready = 1'($urandom_range(0, 1));
      endcase
      if (rready) begin
        a = addr + 32'(4 * got);
        if (got == 0) first = rdata;
        chk("rdata", rdata, model_rd(a));
        chk("rresp", 32'(rresp), oor(a) ? 32'd2 : 32'd0);
        chk("rid", 32'(rid), 32'(id));
        chk("rlast", 32'(rlast), 32'(got == len));
        got++;
        hold = 1'b0;
      end else begin
        hold = 1'b1;
        pd = rdata;
      end
      step();
      to++;
    end
    rready = 1'b0;
    if (got <= len) tmo("read_beats");
    chk("rvalid_done", 32'(rvalid), 32'd0);
  endtask

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic [31:0] exp;
  } vec_t;
  vec_t tbl [7];

  initial begin
    logic [31:0] rd;
    int base, off, len;
    tbl[0] = '{32'h0000_0040, 32'hDEAD_BEEF, 4'hF, 32'hDEAD_BEEF};
    tbl[1] = '{32'h0000_0200, 32'h1122_3344, 4'hF, 32'h1122_3344};
    tbl[2] = '{32'h0000_0200, 32'hAABB_CCDD, 4'h5, 32'h11BB_33DD};
    tbl[3] = '{32'h0000_0200, 32'h0000_0000, 4'h0, 32'h11BB_33DD};
    tbl[4] = '{32'h0000_0200, 32'hFFFF_FFFF, 4'h8, 32'hFFBB_33DD};
    tbl[5] = '{32'h0000_0000, 32'hCAFE_F00D, 4'hF, 32'hCAFE_F00D};
    tbl[6] = '{32'h0000_FFFC, 32'h1234_5678, 4'hF, 32'h1234_5678};

    #3;
    chk("rst_arready", 32'(arready), 32'd1);
    chk("rst_awready", 32'(awready), 32'd1);
    chk("rst_rvalid", 32'(rvalid), 32'd0);
    chk("rst_rlast", 32'(rlast), 32'd0);
    chk("rst_wready", 32'(wready), 32'd0);
    chk("rst_bvalid", 32'(bvalid), 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_ids_resps", 32'({rid, rresp, bid, bresp}), 32'd0);
    #19 rst_n = 1'b1;
    step();

    for (int i = 0; i < 7; i++) begin
      wbuf[0] = tbl[i].wdata; sbuf[0] = tbl[i].strb;
      do_write(tbl[i].addr, 0, 6'(i + 3), 1'b0);
      do_read(tbl[i].addr, 0, 6'(40 + i), 0, rd);
      chk("tbl_readback", rd, tbl[i].exp);
    end

    // 4-beat burst then plain and backpressured readback
    for (int i = 0; i < 4; i++) begin wbuf[i] = 32'(i + 1); sbuf[i] = 4'hF; end
    do_write(32'h100, 3, 6'h15, 1'b0);
    do_read(32'h100, 3, 6'h2A, 0, rd);
    chk("burst_first", rd, 32'd1);
    do_read(32'h100, 3, 6'h3F, 1, rd);

    // reset in beat 2 of a 4-beat read
    araddr = 32'h100; arlen = 8'd3; arid = 6'h11; arvalid = 1'b1;
    step();
    arvalid = 1'b0;
    repeat (LAT) step();
    rready = 1'b1;
    chk("mid_beat1_vld", 32'(rvalid), 32'd1);
    step();
    chk("mid_beat2_data", rdata, 32'd2);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_rvalid", 32'(rvalid), 32'd0);
    chk("mid_rst_arready", 32'(arready), 32'd1);
    chk("mid_rst_rdata", rdata, 32'd0);
    rready = 1'b0;
    step(); step();
    rst_n = 1'b1;
    step();
    chk("post_rst_arready", 32'(arready), 32'd1);
    do_read(32'h100, 3, 6'h05, 0, rd);
    chk("post_rst_first", rd, 32'd1);

    // burst crossing the top of the store, then reads around the boundary
    wbuf[0] = 32'h0BAD_F00D; wbuf[1] = 32'h600D_CAFE; sbuf[0] = 4'hF; sbuf[1] = 4'hF;
    do_write(32'h0000_FFFC, 1, 6'h22, 1'b0);
    do_read(32'h0001_0000, 0, 6'h23, 0, rd);
    do_read(32'h0000_0000, 0, 6'h24, 0, rd);
    do_read(32'h0000_FFF8, 1, 6'h25, 0, rd);

    // random traffic in a fully initialised 64-word window
    base = $urandom_range(1024, 15000);
    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < 16; i++) begin wbuf[i] = $urandom; sbuf[i] = 4'hF; end
      do_write(32'(4 * (base + 16 * k)), 15, 6'(k), 1'b0);
    end
    for (int n = 0; n < 40; n++) begin
      off = $urandom_range(0, 60);
      len = $urandom_range(0, (63 - off) > 15 ? 15 : (63 - off));
      if ($urandom_range(0, 1) == 1) begin
        for (int i = 0; i < 16; i++) begin wbuf[i] = $urandom; sbuf[i] = 4'($urandom); end
        do_write(32'(4 * (base + off)), len, 6'($urandom), 1'b1);
      end else begin
        do_read(32'(4 * (base + off)), len, 6'($urandom), 2, rd);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end
endmodule
